// File: rtl/gpu_cmd_pkg.sv
// gpu_cmd_pkg: command word layout, SPI writer FSM states and MISO status-byte layout.
package gpu_cmd_pkg;

    localparam int CMD_WIDTH    = 72;
    localparam int CMD_RW_BIT   = 71;
    localparam int CMD_ADDR_MSB = 70;
    localparam int CMD_ADDR_LSB = 64;
    localparam int CMD_DATA_MSB = 63;

    typedef logic [CMD_WIDTH-1:0] cmd_word_t;

    typedef enum logic [1:0] {IDLE, SHIFT, COMMIT, TRAIL} spi_wr_state_t;

    localparam int ST_OVERFLOW    = 7;
    localparam int ST_FRAME_ERR   = 6;
    localparam int ST_ALMOST_FULL = 5;
    localparam int ST_FULL        = 4;

    function automatic logic [7:0] status_byte(input logic ovf, input logic ferr,
                                               input logic afull, input logic full);
        logic [7:0] s;
        s = '0;
        s[ST_OVERFLOW]    = ovf;
        s[ST_FRAME_ERR]   = ferr;
        s[ST_ALMOST_FULL] = afull;
        s[ST_FULL]        = full;
        return s;
    endfunction

endpackage

// File: rtl/spi_pin_sync.sv
// spi_pin_sync: multi-flop synchroniser plus rise/fall detector for one asynchronous pin.
module spi_pin_sync #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic wr_clk,
    input  logic wr_rst_n,
    input  logic pin_i,
    output logic lvl_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [SYNC_STAGES:0]   vld_q;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            vld_q  <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
            prev_q <= sync_q[SYNC_STAGES-1];
            vld_q  <= {vld_q[SYNC_STAGES-1:0], 1'b1};
        end
    end

    // Edges are suppressed until the whole chain holds real samples, so a pin that
    // differs from its idle level at reset release never looks like an edge.
    assign lvl_o  = sync_q[SYNC_STAGES-1];
    assign rise_o = vld_q[SYNC_STAGES] & lvl_o & ~prev_q;
    assign fall_o = vld_q[SYNC_STAGES] & ~lvl_o & prev_q;

endmodule

// File: rtl/spi_cmd_writer.sv
// spi_cmd_writer: oversampled SPI mode-0 slave that deserialises 72-bit command frames
// and pushes them into the command FIFO write port, reporting status on MISO.
module spi_cmd_writer
    import gpu_cmd_pkg::*;
#(
    parameter int WIDTH       = CMD_WIDTH,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst_n,
    input  logic                 spi_sck,
    input  logic                 spi_cs_n,
    input  logic                 spi_mosi,
    output logic                 spi_miso,
    output logic                 fifo_wr_en,
    output logic [WIDTH-1:0]     fifo_wr_data,
    input  logic                 fifo_wr_full,
    input  logic                 fifo_wr_almost_full,
    output logic                 host_busy,
    output logic                 overflow,
    output logic                 frame_err,
    input  logic                 status_clr,
    output logic [CNT_WIDTH-1:0] frame_count
);

    localparam int BW = $clog2(WIDTH + 1);

    logic       sck_rise, sck_fall, cs_lvl, cs_rise, cs_fall, mosi_lvl;
    logic [1:0] mosi_edges_unused;

    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .pin_i(spi_sck),
        .lvl_o(), .rise_o(sck_rise), .fall_o(sck_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .pin_i(spi_cs_n),
        .lvl_o(cs_lvl), .rise_o(cs_rise), .fall_o(cs_fall));
    spi_pin_sync #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
        .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .pin_i(spi_mosi),
        .lvl_o(mosi_lvl), .rise_o(mosi_edges_unused[0]), .fall_o(mosi_edges_unused[1]));

    spi_wr_state_t        state_q, state_d;
    logic [WIDTH-1:0]     sr_q, sr_d;
    logic [BW-1:0]        cnt_q, cnt_d;
    logic                 wr_en_q, wr_en_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;
    logic                 ovf_q, ovf_d, ferr_q, ferr_d, busy_q;
    logic [7:0]           miso_q, miso_d;

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    // cs_n rise has priority everywhere, so a coincident sck rise is never counted.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = cs_fall ? SHIFT : IDLE;
            SHIFT:   state_d = cs_rise ? IDLE : (sck_rise && cnt_q == BW'(WIDTH - 1)) ? COMMIT : SHIFT;
            COMMIT:  state_d = cs_rise ? IDLE : TRAIL;
            TRAIL:   state_d = cs_rise ? IDLE : TRAIL;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        logic start, shift, commit;
        start   = (state_q == IDLE) && cs_fall;
        shift   = (state_q == SHIFT) && sck_rise && !cs_rise;
        commit  = (state_q == COMMIT);
        sr_d    = start ? '0 : shift ? {sr_q[WIDTH-2:0], mosi_lvl} : sr_q;
        cnt_d   = start ? '0 : shift ? cnt_q + BW'(1) : cnt_q;
        wr_en_d = commit && !fifo_wr_full;
        count_d = count_q + CNT_WIDTH'(wr_en_d);
        ovf_d   = (commit && fifo_wr_full) || (ovf_q && !status_clr);
        ferr_d  = ((state_q == SHIFT) && cs_rise) || ((state_q == TRAIL) && sck_rise && !cs_rise)
                  || (ferr_q && !status_clr);
        miso_d  = cs_fall ? status_byte(ovf_q, ferr_q, fifo_wr_almost_full, fifo_wr_full) :
                  cs_lvl  ? 8'h00 :
                  sck_fall ? {miso_q[6:0], 1'b0} : miso_q;
    end

    always_ff @(posedge wr_clk or negedge wr_rst_n) begin
        if (!wr_rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            wr_en_q <= 1'b0;
            count_q <= '0;
            ovf_q   <= 1'b0;
            ferr_q  <= 1'b0;
            busy_q  <= 1'b0;
            miso_q  <= '0;
        end else begin
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            wr_en_q <= wr_en_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
            ferr_q  <= ferr_d;
            busy_q  <= fifo_wr_almost_full;
            miso_q  <= miso_d;
        end
    end

    assign spi_miso     = miso_q[7];
    assign fifo_wr_en   = wr_en_q;
    assign fifo_wr_data = sr_q;
    assign host_busy    = busy_q;
    assign overflow     = ovf_q;
    assign frame_err    = ferr_q;
    assign frame_count  = count_q;

endmodule
